sensor_packet_buffer: RTL and testbench

Downstream stage of the S15611 acquisition packetiser. It absorbs the packetiser's AXI-Stream output, which has no backpressure, into a FIFO and re-issues it on an AXI-Stream master with full `tready` handling toward the DMA/interconnect. It also checks packet framing on the input side and keeps status counters for software.

---
 rtl/sensor_packet_buffer.sv | 182 ++++++++++++++++++
 tb/tb_sensor_packet_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_packet_buffer.sv
// sensor_packet_buffer: FIFO buffer from packetiser stream to AXI-Stream master; frame checker when SENSOR_PACKET_BUFFER_FRAME_CHECK_EN is defined.
// Two cycles from write to m_tvalid on an empty FIFO; no input backpressure, so words arriving when full are dropped and counted; output holds while !m_tready.
module sensor_packet_buffer #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              master_clock,
   input  logic              reset,
   input  logic              clear_status,
   input  logic [31:0]       s_tdata,
   input  logic              s_tvalid,
   input  logic              s_tlast,
   output logic [31:0]       m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   input  logic              m_tready,
   output logic [ADDR_W:0]   fifo_level,
   output logic              overflow,
   output logic [15:0]       drop_count,
   output logic              frame_error,
   output logic [15:0]       error_count,
   output logic [15:0]       packet_count
);

   logic [32:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   mem_count;
   logic              mem_vld;
   logic              full;
   logic              wr_acc;
   logic              pop;
   logic              bypass;
   logic              mem_wr;
   logic              mem_rd;

   assign mem_vld    = (mem_count != '0);
   assign fifo_level = mem_count + (ADDR_W+1)'(m_tvalid);
   assign full       = (fifo_level == (ADDR_W+1)'(DEPTH));
   assign wr_acc     = s_tvalid && !full;
   assign pop        = m_tvalid && m_tready;
   // Storage empty while the output register drains: new word goes straight out, no bubble.
   assign bypass     = wr_acc && pop && !mem_vld;
   assign mem_wr     = wr_acc && !bypass;
   assign mem_rd     = mem_vld && (!m_tvalid || m_tready);

   always_ff @(posedge master_clock) begin
      if (mem_wr) mem[wr_ptr] <= {s_tlast, s_tdata};
   end

   always_ff @(posedge master_clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
      end else begin
         if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
         if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
         mem_count <= mem_count + (ADDR_W+1)'(mem_wr) - (ADDR_W+1)'(mem_rd);
      end
   end

   always_ff @(posedge master_clock or posedge reset) begin
      if (reset) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
      end else if (!m_tvalid || m_tready) begin
         if (mem_vld) begin
            m_tvalid            <= 1'b1;
            {m_tlast, m_tdata}  <= mem[rd_ptr];
         end else if (bypass) begin
            m_tvalid            <= 1'b1;
            {m_tlast, m_tdata}  <= {s_tlast, s_tdata};
         end else begin
            m_tvalid            <= 1'b0;
         end
      end
   end

   always_ff @(posedge master_clock or posedge reset) begin
      if (reset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear_status) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (s_tvalid && full) begin
         overflow <= 1'b1;
         if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
   end

`ifdef SENSOR_PACKET_BUFFER_FRAME_CHECK_EN
   typedef enum logic [2:0] {WAIT_HDR, TS1, TS2, PAYLOAD, AFTER_FTR} ck_state_t;
   localparam logic [31:0] HDR      = 32'hAAAAAAAA;
   localparam logic [31:0] FTR      = 32'h55555555;
   localparam logic [31:0] END_WORD = 32'hBBBBBBBB;

   ck_state_t  state;
   ck_state_t  state_nxt;
   logic [9:0] plen;
   logic [9:0] plen_nxt;
   logic       err;
   logic       good;

   always_comb begin
      state_nxt = state;
      plen_nxt  = plen;
      err       = 1'b0;
      good      = 1'b0;
      if (s_tvalid) begin
         if (s_tlast && (s_tdata != END_WORD)) begin
            err       = 1'b1;
            state_nxt = WAIT_HDR;
         end else begin
            if ((s_tdata == END_WORD) && !s_tlast) err = 1'b1;
            case (state)
               WAIT_HDR: begin
                  if (s_tdata == HDR) state_nxt = TS1;
                  else                err       = 1'b1;
               end
               TS1: state_nxt = TS2;
               TS2: begin
                  state_nxt = PAYLOAD;
                  plen_nxt  = '0;
               end
               PAYLOAD: begin
                  if (s_tdata == FTR) begin
                     state_nxt = AFTER_FTR;
                     if ((plen == 10'd3) || (plen == 10'd512)) good = 1'b1;
                     else                                      err  = 1'b1;
                  end else if (plen == 10'd512) begin
                     err       = 1'b1;
                     state_nxt = WAIT_HDR;
                  end else begin
                     plen_nxt = plen + 10'd1;
                  end
               end
               AFTER_FTR: begin
                  if (s_tdata == HDR) begin
                     state_nxt = TS1;
                  end else if ((s_tdata == END_WORD) && s_tlast) begin
                     state_nxt = WAIT_HDR;
                  end else begin
                     err       = 1'b1;
                     state_nxt = WAIT_HDR;
                  end
               end
               default: state_nxt = WAIT_HDR;
            endcase
         end
      end
   end

   always_ff @(posedge master_clock or posedge reset) begin
      if (reset) begin
         state        <= WAIT_HDR;
         plen         <= '0;
         frame_error  <= 1'b0;
         error_count  <= '0;
         packet_count <= '0;
      end else begin
         state       <= state_nxt;
         plen        <= plen_nxt;
         frame_error <= err;
         if (clear_status) begin
            error_count  <= '0;
            packet_count <= '0;
         end else begin
            if (err && (error_count != 16'hFFFF)) error_count <= error_count + 16'd1;
            if (good) packet_count <= packet_count + 16'd1;
         end
      end
   end
`else
   assign frame_error  = 1'b0;
   assign error_count  = '0;
   assign packet_count = '0;
`endif

endmodule

// File: tb/tb_sensor_packet_buffer.sv
// Bench for sensor_packet_buffer: queue-based stream model compared every cycle, plus literal scenario checks.
`timescale 1ns/1ps
module tb_sensor_packet_buffer;
   localparam int DEPTH = 1024;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [31:0] HDR  = 32'hAAAAAAAA;
   localparam logic [31:0] FTR  = 32'h55555555;
   localparam logic [31:0] ENDW = 32'hBBBBBBBB;
`ifdef SENSOR_PACKET_BUFFER_FRAME_CHECK_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic          master_clock = 1'b0;
   logic          reset = 1'b0;
   logic          clear_status = 1'b0;
   logic [31:0]   s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic [31:0]   m_tdata;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready = 1'b0;
   logic [AW:0]   fifo_level;
   logic          overflow;
   logic [15:0]   drop_count;
   logic          frame_error;
   logic [15:0]   error_count;
   logic [15:0]   packet_count;

   sensor_packet_buffer #(.DEPTH(DEPTH)) dut (
      .master_clock(master_clock), .reset(reset), .clear_status(clear_status),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count),
      .frame_error(frame_error), .error_count(error_count), .packet_count(packet_count)
   );

   always #10 master_clock = ~master_clock;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: an ordered list of stored words, each with the first cycle it may be presented.
   typedef struct { logic [31:0] d; logic l; int elig; } ent_t;
   ent_t q[$];
   int   cyc = 0;
   bit   mo_ovf = 0;
   int   mo_drop = 0, mo_err = 0, mo_pkt = 0;
   bit   mo_ferr = 0;
   int   ph = 0, pl = 0;
   int   n_out = 0, n_pulse = 0, peak = 0;
   bit   trk = 0, tog = 0;

   // ph: 0 expect header, 1/2 timestamps, 3 payload (pl words so far), 4 footer seen
   task automatic frame_eval(output bit e, output bit good);
      e = 0; good = 0;
      if (s_tlast && s_tdata != ENDW) begin
         e = 1; ph = 0;
      end else begin
         if (s_tdata == ENDW && !s_tlast) e = 1;
         if (ph == 0) begin
            if (s_tdata == HDR) ph = 1; else e = 1;
         end else if (ph == 1) ph = 2;
         else if (ph == 2) begin ph = 3; pl = 0; end
         else if (ph == 3) begin
            if (s_tdata == FTR) begin
               ph = 4;
               if (pl == 3 || pl == 512) good = 1; else e = 1;
            end else if (pl + 1 > 512) begin e = 1; ph = 0; end
            else pl++;
         end else begin
            if (s_tdata == HDR) ph = 1;
            else if (s_tdata == ENDW && s_tlast) ph = 0;
            else begin e = 1; ph = 0; end
         end
      end
   endtask

   task automatic model_step(input bit mv);
      bit full, popped, e, good;
      e = 0; good = 0;
      full = (q.size() == DEPTH);
      popped = mv && m_tready;
      if (popped) begin void'(q.pop_front()); n_out++; end
      if (s_tvalid && !full)
         q.push_back('{d: s_tdata, l: s_tlast, elig: (popped && q.size() == 0) ? cyc + 1 : cyc + 2});
      if (CK && s_tvalid) frame_eval(e, good);
      mo_ferr = s_tvalid && e;
      if (clear_status) begin
         mo_ovf = 0; mo_drop = 0; mo_err = 0; mo_pkt = 0;
      end else begin
         if (s_tvalid && full) begin mo_ovf = 1; if (mo_drop < 65535) mo_drop++; end
         if (e && mo_err < 65535) mo_err++;
         if (good) mo_pkt = (mo_pkt + 1) % 65536;
      end
      cyc++;
   endtask

   always @(negedge master_clock) begin
      bit mv;
      if (reset) begin
         q.delete(); mo_ovf = 0; mo_drop = 0; mo_err = 0; mo_pkt = 0; mo_ferr = 0; ph = 0; pl = 0;
      end
      mv = 0;
      if (q.size() > 0) mv = (q[0].elig <= cyc);
      chk("m_tvalid", m_tvalid, mv);
      if (mv) begin
         chk("m_tdata", m_tdata, q[0].d);
         chk("m_tlast", m_tlast, q[0].l);
      end
      chk("fifo_level", fifo_level, q.size());
      chk("overflow", overflow, mo_ovf);
      chk("drop_count", drop_count, mo_drop);
      chk("frame_error", frame_error, mo_ferr);
      chk("error_count", error_count, mo_err);
      chk("packet_count", packet_count, mo_pkt);
      if (frame_error) n_pulse++;
      if (!trk) peak = 0;
      else if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (!reset) model_step(mv);
   end

   task automatic send(input logic [31:0] d, input bit l, input bit clr = 0);
      @(posedge master_clock); #1;
      if (tog) m_tready = !m_tready;
      s_tdata = d; s_tvalid = 1'b1; s_tlast = l; clear_status = clr;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge master_clock); #1;
         s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; clear_status = 1'b0;
      end
   endtask

   task automatic send_pkt(input int npay, input bit with_end);
      send(HDR, 0); send(32'h0000_1111, 0); send(32'h0000_2222, 0);
      for (int i = 0; i < npay; i++) send(32'h1000_0000 + i, 0);
      send(FTR, 0);
      if (with_end) send(ENDW, 1);
   endtask

   initial begin
      int base, p0;
      #1 reset = 1'b1;
      @(posedge master_clock); #1;
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_err", error_count, 0);
      repeat (2) @(posedge master_clock);
      #1 reset = 1'b0;

      // processed packet
      m_tready = 1'b1;
      base = n_out;
      send(HDR, 0); send(32'h0000_1111, 0);
      @(negedge master_clock); chk("lat_edge1", m_tvalid, 0);
      send(32'h0000_2222, 0);
      @(negedge master_clock); chk("lat_edge2", m_tvalid, 1); chk("lat_data", m_tdata, HDR);
      for (int i = 0; i < 3; i++) send(32'h1000_0000 + i, 0);
      send(FTR, 0); send(ENDW, 1);
      idle(6);
      chk("proc_words", n_out - base, 8);
      chk("proc_pkt", packet_count, CK ? 1 : 0);
      chk("proc_err", error_count, 0);

      // raw packet with ready toggling
      base = n_out; tog = 1; trk = 1;
      send_pkt(512, 0);
      p0 = peak; tog = 0; trk = 0;
      m_tready = 1'b1;
      idle(300);
      chk("raw_words", n_out - base, 516);
      chk("raw_peak_ok", (p0 >= 250 && p0 <= 265), 1);
      chk("raw_drop", drop_count, 0);
      chk("raw_pkt", packet_count, CK ? 2 : 0);

      // bad framing
      base = n_pulse;
      send(32'h1234_5678, 0);
      send_pkt(5, 0);
      send(32'h0000_0077, 1);
      idle(4);
      chk("bad_pulses", n_pulse - base, CK ? 3 : 0);
      chk("bad_err", error_count, CK ? 3 : 0);

      // clear_status coincident with an error
      send(32'h0BAD_BEEF, 0, 1);
      idle(3);
      chk("clr_err", error_count, 0);
      chk("clr_pkt", packet_count, 0);

      // overflow
      m_tready = 1'b0; base = n_out;
      for (int i = 0; i < DEPTH + 4; i++) send(32'h2000_0000 + i, 0);
      idle(3);
      chk("ovf_level", fifo_level, DEPTH);
      chk("ovf_flag", overflow, 1);
      chk("ovf_drop", drop_count, 4);
      @(negedge master_clock); chk("ovf_head", m_tdata, 32'h2000_0000);
      @(posedge master_clock); #1 m_tready = 1'b1;
      idle(DEPTH + 10);
      chk("ovf_drained", n_out - base, DEPTH);
      chk("ovf_empty", fifo_level, 0);
      send(32'h0000_0000, 0, 1); s_tvalid = 1'b0;
      idle(2);
      chk("ovf_clr_flag", overflow, 0);
      chk("ovf_clr_drop", drop_count, 0);

      // asynchronous reset mid-packet
      m_tready = 1'b0;
      send(HDR, 0); send(32'h0000_1111, 0); send(32'h0000_2222, 0); send(32'h1000_0000, 0);
      @(posedge master_clock); #5 reset = 1'b1; s_tvalid = 1'b0;
      #1;
      chk("mid_tvalid", m_tvalid, 0);
      chk("mid_level", fifo_level, 0);
      @(posedge master_clock); #1 reset = 1'b0;
      m_tready = 1'b1;
      send_pkt(3, 1);
      idle(6);
      chk("post_pkt", packet_count, CK ? 1 : 0);
      chk("post_err", error_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
